// File: rtl/mmbuf_pkg.sv
// mmbuf_pkg: para field layout, funct3 codes, FSM states and queue entry type
// shared by the memory/multiply issue buffer and its alignment helper.
package mmbuf_pkg;

    localparam int MMBUF_PARA_LEN = 10;

    localparam int PARA_MUL   = 9;
    localparam int PARA_RD_HI = 8;
    localparam int PARA_RD_LO = 4;
    localparam int PARA_ST    = 3;
    localparam int PARA_F3_HI = 2;
    localparam int PARA_F3_LO = 0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [MMBUF_PARA_LEN-1:0] para;
        logic [31:0]               addr;
        logic [31:0]               wdata;
    } entry_t;

    function automatic logic [4:0] para_rd(input logic [MMBUF_PARA_LEN-1:0] p);
        return p[PARA_RD_HI:PARA_RD_LO];
    endfunction

    function automatic logic [2:0] para_f3(input logic [MMBUF_PARA_LEN-1:0] p);
        return p[PARA_F3_HI:PARA_F3_LO];
    endfunction

endpackage

// File: rtl/mmbuf_align.sv
// mmbuf_align: store byte-enable and lane replication, load byte/half extract
// and sign/zero extension; purely combinational.
module mmbuf_align
    import mmbuf_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        ld_b    = rdata[{addr_lo, 3'b000} +: 8];
        ld_h    = rdata[{addr_lo[1], 4'b0000} +: 16];
        st_be   = funct3 == F3_SB ? 4'b0001 << addr_lo
                : funct3 == F3_SH ? (addr_lo[1] ? 4'b1100 : 4'b0011)
                : 4'b1111;
        st_data = funct3 == F3_SB ? {4{wdata[7:0]}}
                : funct3 == F3_SH ? {2{wdata[15:0]}}
                : wdata;
        ld_data = funct3 == F3_LB  ? {{24{ld_b[7]}}, ld_b}
                : funct3 == F3_LBU ? {24'h0, ld_b}
                : funct3 == F3_LH  ? {{16{ld_h[15]}}, ld_h}
                : funct3 == F3_LHU ? {16'h0, ld_h}
                : rdata;
    end

endmodule

// File: rtl/mmbuf.sv
// mmbuf: in-order memory/multiply issue buffer; queues ALU beats, issues loads and
// stores on the data bus oldest first, and hands multiplies to the multiplier.
module mmbuf
    import mmbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_vld,
    input  logic [MMBUF_PARA_LEN-1:0] mem_para,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    output logic                      mmbuf_full,
    output logic                      mmbuf_empty,
    output logic                      ovf_err,
    output logic [31:0]               rd_pending,
    output logic                      dbus_req,
    output logic                      dbus_we,
    output logic [31:0]               dbus_addr,
    output logic [3:0]                dbus_be,
    output logic [31:0]               dbus_wdata,
    input  logic                      dbus_gnt,
    input  logic                      dbus_rvld,
    input  logic [31:0]               dbus_rdata,
    output logic                      mul_vld,
    input  logic                      mul_rdy,
    output logic [4:0]                mul_rd,
    output logic [2:0]                mul_func,
    output logic [31:0]               mul_op1,
    output logic [31:0]               mul_op2,
    output logic [4:0]                mem_sel,
    output logic [31:0]               mem_data
);

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0]   count;
    state_e           state, state_nx;
    logic [4:0]       fl_rd;
    logic [2:0]       fl_f3;
    logic [1:0]       fl_lo;
    logic             head_vld, head_mul, head_st, enq, deq, wb;
    logic [3:0]       st_be;
    logic [31:0]      st_data, ld_data;

    assign head       = mem[rptr];
    assign head_vld   = count != '0;
    assign head_mul   = head.para[PARA_MUL];
    assign head_st    = head.para[PARA_ST];
    assign mmbuf_full = count == (PTR_W+1)'(DEPTH);
    assign enq        = mem_vld && !mmbuf_full;
    assign deq        = (state == S_IDLE && head_vld && head_mul && mul_rdy) || (state == S_REQ && dbus_gnt);
    assign wb         = state == S_WAIT && dbus_rvld && fl_rd != '0;

    always_ff @(posedge clk)
        if (enq) mem[wptr] <= {mem_para, mem_addr, mem_wdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            wptr    <= wptr + PTR_W'(enq);
            rptr    <= rptr + PTR_W'(deq);
            count   <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
            ovf_err <= ovf_err | (mem_vld & mmbuf_full);
        end
    end

    // Only the fields needed to steer and extend the returning data survive the dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            {fl_rd, fl_f3, fl_lo} <= '0;
        else if (state == S_REQ && dbus_gnt && !head_st)
            {fl_rd, fl_f3, fl_lo} <= {para_rd(head.para), para_f3(head.para), head.addr[1:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (head_vld && !head_mul) state_nx = S_REQ;
            S_REQ:   if (dbus_gnt) state_nx = head_st ? S_IDLE : S_WAIT;
            S_WAIT:  if (dbus_rvld) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    mmbuf_align u_align (
        .funct3  (state == S_WAIT ? fl_f3 : para_f3(head.para)),
        .addr_lo (state == S_WAIT ? fl_lo : head.addr[1:0]),
        .wdata   (head.wdata),
        .rdata   (dbus_rdata),
        .st_be   (st_be),
        .st_data (st_data),
        .ld_data (ld_data)
    );

    always_comb begin
        mmbuf_empty = count == '0 && state == S_IDLE;
        dbus_req    = state == S_REQ;
        dbus_we     = dbus_req && head_st;
        dbus_addr   = dbus_req ? {head.addr[31:2], 2'b00} : '0;
        dbus_be     = !dbus_req ? 4'b0000 : head_st ? st_be : 4'b1111;
        dbus_wdata  = dbus_we ? st_data : '0;
        mul_vld     = state == S_IDLE && head_vld && head_mul;
        mul_rd      = mul_vld ? para_rd(head.para) : '0;
        mul_func    = mul_vld ? para_f3(head.para) : '0;
        mul_op1     = mul_vld ? head.addr : '0;
        mul_op2     = mul_vld ? head.wdata : '0;
        mem_sel     = wb ? fl_rd : '0;
        mem_data    = wb ? ld_data : '0;
    end

    // Queue slots are live when their distance from rptr is below count.
    always_comb begin
        rd_pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PTR_W'(i) - rptr} < count && (mem[i].para[PARA_MUL] || !mem[i].para[PARA_ST]))
                rd_pending[para_rd(mem[i].para)] = 1'b1;
        if (state == S_WAIT) rd_pending[fl_rd] = 1'b1;
        rd_pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_mmbuf.sv
// tb_mmbuf: directed stimulus for mmbuf with a queue-based reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_mmbuf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_vld = 1'b0;
    logic [9:0]  mem_para = '0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic        mmbuf_full, mmbuf_empty, ovf_err;
    logic [31:0] rd_pending;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt = 1'b0, dbus_rvld = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        mul_vld, mul_rdy = 1'b0;
    logic [4:0]  mul_rd, mem_sel;
    logic [2:0]  mul_func;
    logic [31:0] mul_op1, mul_op2, mem_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmbuf #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .mem_vld(mem_vld), .mem_para(mem_para), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mmbuf_full(mmbuf_full), .mmbuf_empty(mmbuf_empty), .ovf_err(ovf_err), .rd_pending(rd_pending),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvld(dbus_rvld), .dbus_rdata(dbus_rdata),
        .mul_vld(mul_vld), .mul_rdy(mul_rdy), .mul_rd(mul_rd), .mul_func(mul_func),
        .mul_op1(mul_op1), .mul_op2(mul_op2), .mem_sel(mem_sel), .mem_data(mem_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of decoded entries and the bus phase
    // (0 = nothing outstanding, 1 = requesting, 2 = awaiting read data).
    typedef struct {
        bit        mul;
        bit [4:0]  rd;
        bit        st;
        bit [2:0]  f3;
        bit [31:0] a;
        bit [31:0] d;
    } ent_t;

    ent_t q[$];
    ent_t fl;
    int   ph = 0;
    bit   m_ovf = 0;
    bit   mv, wbx;

    function automatic logic [3:0] exp_be(ent_t e);
        logic [3:0] be;
        if (!e.st) return 4'hF;
        if (e.f3 == 3'b000) begin
            be = 4'h0;
            be[e.a[1:0]] = 1'b1;
            return be;
        end
        if (e.f3 == 3'b001) return e.a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(ent_t e);
        if (e.f3 == 3'b000) return {4{e.d[7:0]}};
        if (e.f3 == 3'b001) return {2{e.d[15:0]}};
        return e.d;
    endfunction

    function automatic logic [31:0] exp_ld(ent_t e, logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        b = r[8*e.a[1:0] +: 8];
        h = e.a[1] ? r[31:16] : r[15:0];
        case (e.f3)
            3'b000:  return 32'(signed'(b));
            3'b100:  return 32'(b);
            3'b001:  return 32'(signed'(h));
            3'b101:  return 32'(h);
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] exp_pend();
        logic [31:0] p;
        p = '0;
        foreach (q[i]) if (q[i].mul || !q[i].st) p[q[i].rd] = 1'b1;
        if (ph == 2) p[fl.rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            ph = 0;
            m_ovf = 0;
        end else begin
            bit deq, was_full;
            deq = 0;
            was_full = q.size() == DEPTH;
            if (ph == 0 && q.size() != 0) begin
                if (q[0].mul) deq = mul_rdy;
                else ph = 1;
            end else if (ph == 1 && dbus_gnt) begin
                deq = 1;
                if (q[0].st) ph = 0;
                else begin
                    fl = q[0];
                    ph = 2;
                end
            end else if (ph == 2 && dbus_rvld) ph = 0;
            if (deq) q.delete(0);
            if (mem_vld) begin
                if (was_full) m_ovf = 1;
                else q.push_back('{mem_para[9], mem_para[8:4], mem_para[3] && !mem_para[9], mem_para[2:0], mem_addr, mem_wdata});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("full", mmbuf_full, q.size() == DEPTH);
            chk("empty", mmbuf_empty, q.size() == 0 && ph == 0);
            chk("ovf_err", ovf_err, m_ovf);
            chk("rd_pending", rd_pending, exp_pend());
            chk("dbus_req", dbus_req, ph == 1);
            if (ph == 1) begin
                chk("dbus_we", dbus_we, q[0].st);
                chk("dbus_addr", dbus_addr, {q[0].a[31:2], 2'b00});
                chk("dbus_be", dbus_be, exp_be(q[0]));
                if (q[0].st) chk("dbus_wdata", dbus_wdata, exp_wdata(q[0]));
            end
            mv = ph == 0 && q.size() != 0 && q[0].mul;
            chk("mul_vld", mul_vld, mv);
            if (mv) begin
                chk("mul_rd", mul_rd, q[0].rd);
                chk("mul_func", mul_func, q[0].f3);
                chk("mul_op1", mul_op1, q[0].a);
                chk("mul_op2", mul_op2, q[0].d);
            end
            wbx = ph == 2 && dbus_rvld && fl.rd != 0;
            chk("mem_sel", mem_sel, wbx ? fl.rd : 5'd0);
            chk("mem_data", mem_data, wbx ? exp_ld(fl, dbus_rdata) : 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_set(input logic [9:0] p, input logic [31:0] a, input logic [31:0] d);
        cyc();
        mem_vld = 1'b1;
        mem_para = p;
        mem_addr = a;
        mem_wdata = d;
    endtask

    task automatic idle();
        cyc();
        mem_vld = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        @(negedge clk);
        while (!dbus_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_req_timeout"}, dbus_req, 1'b1);
    endtask

    task automatic serve_load(input logic [31:0] r, input logic [4:0] sel, input logic [31:0] data, input string nm);
        wait_req(nm);
        cyc();
        dbus_gnt = 1'b1;
        cyc();
        dbus_gnt = 1'b0;
        dbus_rvld = 1'b1;
        dbus_rdata = r;
        @(negedge clk);
        chk({nm, "_sel"}, mem_sel, sel);
        chk({nm, "_data"}, mem_data, data);
        cyc();
        dbus_rvld = 1'b0;
        @(negedge clk);
        chk({nm, "_sel_pulse"}, mem_sel, 5'd0);
    endtask

    initial begin
        logic [31:0] seen[$];
        @(negedge clk);
        chk("rst_empty", mmbuf_empty, 1'b1);
        chk("rst_full", mmbuf_full, 1'b0);
        chk("rst_req", dbus_req, 1'b0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_pend", rd_pending, 32'h0);
        chk("rst_sel", mem_sel, 5'd0);
        cyc();
        rst = 1'b1;

        // SB to 0x1003, grant held off for two request cycles
        enq_set(10'h008, 32'h0000_1003, 32'h0000_00AB);
        idle();
        @(negedge clk);
        chk("sb_first_idle", dbus_req, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("sb_req", dbus_req, 1'b1);
            chk("sb_addr", dbus_addr, 32'h0000_1000);
            chk("sb_be", dbus_be, 4'b1000);
            chk("sb_wdata", dbus_wdata, 32'hABAB_ABAB);
        end
        cyc();
        dbus_gnt = 1'b1;
        cyc();
        dbus_gnt = 1'b0;
        @(negedge clk);
        chk("sb_done_req", dbus_req, 1'b0);
        chk("sb_done_empty", mmbuf_empty, 1'b1);

        // LB and LHU on the same bus word
        enq_set(10'h050, 32'h0000_2001, 32'h0);
        idle();
        serve_load(32'h1234_80FF, 5'd5, 32'hFFFF_FF80, "lb");
        enq_set(10'h065, 32'h0000_2002, 32'h0);
        idle();
        serve_load(32'h1234_80FF, 5'd6, 32'h0000_1234, "lhu");

        // five back-to-back SWs with no grant: the fifth is dropped
        for (int i = 0; i < 4; i++) enq_set(10'h00A, 32'h100 + 32'(4 * i), 32'(i));
        enq_set(10'h00A, 32'h110, 32'h4);
        @(negedge clk);
        chk("ovf_full4", mmbuf_full, 1'b1);
        chk("ovf_before", ovf_err, 1'b0);
        idle();
        @(negedge clk);
        chk("ovf_after", ovf_err, 1'b1);
        chk("ovf_still_full", mmbuf_full, 1'b1);
        cyc();
        dbus_gnt = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dbus_req) seen.push_back(dbus_addr);
        end
        cyc();
        dbus_gnt = 1'b0;
        chk("ovf_txn_count", seen.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < seen.size()) chk("ovf_txn_addr", seen[i], 32'h100 + 32'(4 * i));

        // load rd3, mul rd7, load rd0
        mul_rdy = 1'b1;
        enq_set(10'h032, 32'h0000_3000, 32'h0);
        enq_set(10'h270, 32'd6, 32'd7);
        enq_set(10'h002, 32'h0000_3004, 32'h0);
        idle();
        @(negedge clk);
        chk("mix_pend", rd_pending, 32'h0000_0088);
        chk("mix_no_mul", mul_vld, 1'b0);
        serve_load(32'hDEAD_BEEF, 5'd3, 32'hDEAD_BEEF, "mix_ld3");
        chk("mix_mul_vld", mul_vld, 1'b1);
        chk("mix_mul_rd", mul_rd, 5'd7);
        chk("mix_mul_op1", mul_op1, 32'd6);
        chk("mix_mul_op2", mul_op2, 32'd7);
        chk("mix_pend_mul", rd_pending, 32'h0000_0080);
        @(negedge clk);
        chk("mix_mul_done", mul_vld, 1'b0);
        chk("mix_pend_clr", rd_pending, 32'h0);
        serve_load(32'h0000_0055, 5'd0, 32'h0, "mix_ld0");
        mul_rdy = 1'b0;

        // stray read data while idle
        cyc();
        dbus_rvld = 1'b1;
        dbus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("stray_sel", mem_sel, 5'd0);
        chk("stray_data", mem_data, 32'h0);
        cyc();
        dbus_rvld = 1'b0;

        // reset in the middle of a request with two entries queued
        enq_set(10'h00A, 32'h400, 32'h11);
        enq_set(10'h00A, 32'h404, 32'h22);
        idle();
        wait_req("rstmid");
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_req", dbus_req, 1'b0);
        chk("rstmid_empty", mmbuf_empty, 1'b1);
        chk("rstmid_ovf", ovf_err, 1'b0);
        chk("rstmid_full", mmbuf_full, 1'b0);
        cyc();
        dbus_rvld = 1'b1;
        dbus_rdata = 32'h1234_5678;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("late_rvld_sel", mem_sel, 5'd0);
        chk("late_rvld_empty", mmbuf_empty, 1'b1);
        cyc();
        dbus_rvld = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/mmbuf.md
Name: mmbuf

Overview:
- In-order memory/multiply issue buffer directly downstream of the execute ALU.
- Captures each mem_vld beat (para, effective address, store data) into a FIFO.
- Issues loads and stores, oldest first, on the data bus with a req/gnt handshake, aligns and extends load data, and returns it to the register file.
- Hands multiply entries to the multiplier through a valid/ready port.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_vld  in  1  enqueue strobe from the ALU.
- mem_para  in  `MMBUF_PARA_LEN (10)  bit9 = mul, [8:4] = rd, bit3 = store, [2:0] = funct3.
- mem_addr  in  32  effective address; for mul entries, operand 1.
- mem_wdata  in  32  store data; for mul entries, operand 2.
- mmbuf_full  out  1  count==DEPTH; upstream must not issue while high.
- mmbuf_empty  out  1  count==0 and FSM in IDLE.
- ovf_err  out  1  sticky: an enqueue arrived while full.
- rd_pending  out  32  bitmap of rd for queued or in-flight loads and muls; bit0 is always 0.
- dbus_req  out  1  bus request.
- dbus_we  out  1  1 = store.
- dbus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dbus_be  out  4  byte enables.
- dbus_wdata  out  32  lane-replicated store data.
- dbus_gnt  in  1  request accepted.
- dbus_rvld  in  1  load data valid.
- dbus_rdata  in  32  load data.
- mul_vld  out  1  mul entry at head.
- mul_rdy  in  1  multiplier accepts.
- mul_rd  out  5  mul destination register.
- mul_func  out  3  mul funct3.
- mul_op1  out  32  multiply operand 1.
- mul_op2  out  32  multiply operand 2.
- mem_sel  out  5  load writeback register; 0 = no write.
- mem_data  out  32  load writeback data.

Behaviour:
- Reset (rst low, async): pointers and count = 0, FSM = IDLE, ovf_err = 0, all outputs 0 except mmbuf_empty = 1.
- Enqueue: on clk when mem_vld and count<DEPTH, write the entry at wptr and increment wptr (wraps modulo DEPTH).
- Enqueue while full: the entry is dropped and ovf_err set, even if a dequeue happens in the same cycle.
- Simultaneous enqueue and dequeue when not full: count unchanged.
- Entry timing: an entry written in cycle N is first visible at the head in cycle N+1.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If the head is valid and bit9 = 0, go to REQ; dbus_req is asserted from the next cycle.
  - If the head is valid and bit9 = 1, drive mul_vld combinationally from the head. On mul_vld & mul_rdy, dequeue and stay in IDLE.
- REQ:
  - Hold dbus_req and all dbus_* outputs stable until dbus_gnt.
  - Store + gnt: dequeue, go to IDLE.
  - Load + gnt: dequeue into an in-flight register (rd, funct3, addr[1:0]), go to WAIT.
- WAIT: on dbus_rvld, pulse mem_sel/mem_data for exactly 1 cycle, go to IDLE.
  - dbus_rvld in the same cycle as gnt is not supported; the bus returns data at least 1 cycle after gnt.
- Minimum load throughput: 1 per 3 cycles; minimum store throughput: 1 per 2 cycles.
- Store byte enables and data by funct3:
  - SB (000): be = 1 << addr[1:0], data = {4{wdata[7:0]}}.
  - SH (001): be = addr[1] ? 1100 : 0011, data = {2{wdata[15:0]}}.
  - SW (010) or other: be = 1111, data = wdata.
- Load be = 1111 always.
- Load extract: byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]).
- Load extend:
  - LB: sign-extend byte. LBU: zero-extend byte.
  - LH: sign-extend half. LHU: zero-extend half.
  - LW: full word.
- addr[0] is ignored for halfwords; alignment exceptions are out of scope.
- rd = 0 load: performs the bus access, mem_sel = 0, no writeback.
- rd_pending: OR of the one-hot decode of rd over valid queued non-store entries plus the in-flight load; bit0 is forced 0.
- rd_pending timing: set the cycle after enqueue, cleared the cycle after writeback or mul handoff.
- Reset mid-transaction: abandons the FSM and queue; a late dbus_rvld in IDLE is ignored.

Decomposition:
- Shared package/define file:
  - MMBUF_PARA_LEN.
  - Para field offsets: PARA_MUL = 9, PARA_RD = 8:4, PARA_ST = 3, PARA_F3 = 2:0.
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - FSM state encodings.
- One sub-module is natural: mmbuf_align, a combinational store be/data generator and load extract/extend, reused by later cache work.

Test Plan:
- Reset: rst low mid-REQ with 2 entries queued -> dbus_req = 0 and mmbuf_empty = 1 immediately; ovf_err = 0.
- SB: store, funct3 = 000, addr = 0x1003, wdata = 0xAB, gnt after 2 cycles -> dbus_addr = 0x1000, be = 1000, wdata = 0xABABABAB; req held stable until gnt.
- LB/LHU:
  - LB addr 0x2001, rdata = 0x1234_80FF, rd = 5 -> mem_sel = 5, mem_data = 0xFFFFFF80, 1-cycle pulse.
  - LHU addr 0x2002 on the same data -> mem_data = 0x00001234.
- Full and overflow: 5 enqueues back-to-back with gnt = 0, DEPTH = 4 -> mmbuf_full after the 4th, ovf_err = 1, 5th dropped.
  - Then grant all -> exactly 4 bus transactions in order, wptr wraps correctly.
- Mul interleave: load rd = 3, mul rd = 7 (op1 = 6, op2 = 7), load rd = 0.
  - rd_pending = 0x88 while queued.
  - mul_vld only after the first load writes back; cleared after the mul handshake.
  - The rd = 0 load gives mem_sel = 0.
- Rvld stray: dbus_rvld pulse while IDLE -> no writeback.
